// File: rtl/lcd_ctrl.sv
// lcd_ctrl
//   Display-side end of the CPU LCD output register. Byte writes (command or
//   data) from the LSU are buffered in a small FIFO, then serialised onto an
//   HD44780-style 8-bit parallel bus with setup / enable / hold / settle timing.
//
// Handshake: a write {i_wr_rs, i_wr_data} is accepted on a rising clock edge
//   where i_wr_vld & o_wr_rdy. o_wr_rdy depends only on FIFO occupancy, never
//   on i_wr_vld. A write offered while o_wr_rdy=0 is dropped.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_wr_vld / o_wr_rdy / i_wr_rs / i_wr_data : LSU write port
//   i_lcd_on -> o_lcd_on                      : power pin, one flop delay
//   o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data  : LCD bus (rw tied low)
//   o_busy        : transfer in progress or FIFO non-empty
//   o_fifo_level  : FIFO occupancy
//   o_dbg_state   : current FSM state encoding
module lcd_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int T_SETUP    = 2,
    parameter int T_EN       = 12,
    parameter int T_HOLD     = 2,
    parameter int T_CMD_WAIT = 2000,
    parameter int T_CLR_WAIT = 82000
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_wr_vld,
    output logic                          o_wr_rdy,
    input  logic                          i_wr_rs,
    input  logic [7:0]                    i_wr_data,
    input  logic                          i_lcd_on,
    output logic                          o_lcd_on,
    output logic                          o_lcd_en,
    output logic                          o_lcd_rs,
    output logic                          o_lcd_rw,
    output logic [7:0]                    o_lcd_data,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [2:0]                    o_dbg_state
);

    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int LW       = AW + 1;
    localparam int MAX_WAIT = (T_CLR_WAIT > T_CMD_WAIT) ? T_CLR_WAIT : T_CMD_WAIT;
    localparam int MAX_A    = (MAX_WAIT > T_EN) ? MAX_WAIT : T_EN;
    localparam int MAX_B    = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
    localparam int MAX_LOAD = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW       = $clog2(MAX_LOAD + 1);

    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_EN    = CW'(T_EN - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_CMD   = CW'(T_CMD_WAIT - 1);
    localparam logic [CW-1:0] LD_CLR   = CW'(T_CLR_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        WAIT  = 3'd4
    } state_t;

    // FIFO
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [LW-1:0] level_q;
    logic          push;
    logic          pop;

    // FSM / bus registers
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          en_q;
    logic          rs_q;
    logic [7:0]    data_q;
    logic          on_q;
    logic          is_long;

    assign o_wr_rdy = (level_q < LW'(FIFO_DEPTH));
    assign push     = i_wr_vld & o_wr_rdy;
    assign pop      = (state_q == IDLE) && (level_q != '0);

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wptr_q] <= {i_wr_rs, i_wr_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Clear display (0x01) and return home (0x02/0x03) need the long settle.
    assign is_long = ~rs_q & ((data_q == 8'h01) | (data_q[7:1] == 7'h01));

    // One down-counter serves every timed state; each state loads the
    // next state's duration minus one when its own count reaches zero.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        {rs_q, data_q} <= mem_q[rptr_q];
                        cnt_q          <= LD_SETUP;
                        state_q        <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= LD_EN;
                        en_q    <= 1'b1;
                        state_q <= PULSE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= LD_HOLD;
                        en_q    <= 1'b0;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= is_long ? LD_CLR : LD_CMD;
                        state_q <= WAIT;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    en_q    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            on_q <= 1'b0;
        end else begin
            on_q <= i_lcd_on;
        end
    end

    assign o_lcd_on     = on_q;
    assign o_lcd_en     = en_q;
    assign o_lcd_rs     = rs_q;
    assign o_lcd_rw     = 1'b0;
    assign o_lcd_data   = data_q;
    assign o_busy       = (state_q != IDLE) || (level_q != '0);
    assign o_fifo_level = level_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
module tb_lcd_ctrl;

  localparam int DEPTH  = 4;
  localparam int TSETUP = 2;
  localparam int TEN    = 3;
  localparam int THOLD  = 2;
  localparam int TCMD   = 5;
  localparam int TCLR   = 20;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_wr_vld;
  logic       o_wr_rdy;
  logic       i_wr_rs;
  logic [7:0] i_wr_data;
  logic       i_lcd_on;
  logic       o_lcd_on;
  logic       o_lcd_en;
  logic       o_lcd_rs;
  logic       o_lcd_rw;
  logic [7:0] o_lcd_data;
  logic       o_busy;
  logic [2:0] o_fifo_level;
  logic [2:0] o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         settle;   // cycles from EN fall to o_busy fall (T_HOLD + wait)
    string      name;
  } vec_t;

  vec_t vecs[9];

  lcd_ctrl #(
    .FIFO_DEPTH(DEPTH),
    .T_SETUP   (TSETUP),
    .T_EN      (TEN),
    .T_HOLD    (THOLD),
    .T_CMD_WAIT(TCMD),
    .T_CLR_WAIT(TCLR)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_wr_vld    (i_wr_vld),
    .o_wr_rdy    (o_wr_rdy),
    .i_wr_rs     (i_wr_rs),
    .i_wr_data   (i_wr_data),
    .i_lcd_on    (i_lcd_on),
    .o_lcd_on    (o_lcd_on),
    .o_lcd_en    (o_lcd_en),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_rw    (o_lcd_rw),
    .o_lcd_data  (o_lcd_data),
    .o_busy      (o_busy),
    .o_fifo_level(o_fifo_level),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- bus monitor / scoreboard ----------------
  logic       en_prev = 1'b0;
  int         hi_cnt  = 0;
  logic [8:0] cap     = '0;

  always @(negedge clk) begin
    if (!i_reset) begin
      en_prev = 1'b0;
      hi_cnt  = 0;
    end else begin
      if (o_lcd_en && !en_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: actual=%0h required=none", {o_lcd_rs, o_lcd_data});
        end else begin
          check("pulse_byte", {o_lcd_rs, o_lcd_data}, exp_q.pop_front());
        end
        hi_cnt = 1;
        cap    = {o_lcd_rs, o_lcd_data};
      end else if (o_lcd_en) begin
        hi_cnt++;
      end else if (en_prev) begin
        check("en_width", hi_cnt, TEN);
        check("hold_byte", {o_lcd_rs, o_lcd_data}, cap);
      end
      check("rw_low", o_lcd_rw, 1'b0);
      en_prev = o_lcd_en;
    end
  end

  // ---------------- driver tasks ----------------
  // Single write into an idle controller; measures the full transfer timeline.
  task automatic send_single(input logic rs, input logic [7:0] d, input int settle, input string tag);
    int c;
    int t_rise;
    int t_fall;
    int t_idle;
    @(negedge clk);
    check({tag, "_rdy"}, o_wr_rdy, 1'b1);
    check({tag, "_idle_busy"}, o_busy, 1'b0);
    i_wr_vld  = 1'b1;
    i_wr_rs   = rs;
    i_wr_data = d;
    exp_q.push_back({rs, d});
    c = 0; t_rise = -1; t_fall = -1; t_idle = -1;
    while (t_idle < 0 && c < 200) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        i_wr_vld = 1'b0;
        check({tag, "_busy"}, o_busy, 1'b1);
      end
      if (c == 2 || c == 8) check({tag, "_bus_stable"}, {o_lcd_rs, o_lcd_data}, {rs, d});
      if (t_rise < 0 && o_lcd_en) t_rise = c;
      if (t_rise >= 0 && t_fall < 0 && !o_lcd_en) t_fall = c;
      if (t_fall >= 0 && !o_busy) t_idle = c;
    end
    check({tag, "_en_rise"}, t_rise, 2 + TSETUP);
    check({tag, "_en_fall"}, t_fall, 2 + TSETUP + TEN);
    check({tag, "_settle"}, t_idle - t_fall, settle);
    check({tag, "_bus_kept"}, {o_lcd_rs, o_lcd_data}, {rs, d});
  endtask

  // Offer a byte, waiting for o_wr_rdy first; called at a negedge.
  task automatic offer(input logic rs, input logic [7:0] d);
    int n;
    n = 0;
    while (!o_wr_rdy && n < 200) begin
      i_wr_vld = 1'b0;
      @(negedge clk);
      n++;
    end
    check("offer_rdy", o_wr_rdy, 1'b1);
    i_wr_vld  = 1'b1;
    i_wr_rs   = rs;
    i_wr_data = d;
    exp_q.push_back({rs, d});
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (o_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, o_busy, 1'b0);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  logic exp_rdy [6];
  int   t;

  initial begin
    vecs[0] = '{1'b1, 8'h41, THOLD + TCMD, "data_41"};
    vecs[1] = '{1'b0, 8'h01, THOLD + TCLR, "cmd_clear"};
    vecs[2] = '{1'b0, 8'h38, THOLD + TCMD, "cmd_38"};
    vecs[3] = '{1'b0, 8'h02, THOLD + TCLR, "cmd_home2"};
    vecs[4] = '{1'b0, 8'h03, THOLD + TCLR, "cmd_home3"};
    vecs[5] = '{1'b1, 8'h01, THOLD + TCMD, "data_01"};
    vecs[6] = '{1'b0, 8'h00, THOLD + TCMD, "cmd_00"};
    vecs[7] = '{1'b0, 8'h04, THOLD + TCMD, "cmd_04"};
    vecs[8] = '{1'b0, 8'h81, THOLD + TCMD, "cmd_81"};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    i_reset   = 1'b0;
    i_wr_vld  = 1'b0;
    i_wr_rs   = 1'b0;
    i_wr_data = 8'h00;
    i_lcd_on  = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_en", o_lcd_en, 1'b0);
    check("rst_rs", o_lcd_rs, 1'b0);
    check("rst_data", o_lcd_data, 8'h00);
    check("rst_busy", o_busy, 1'b0);
    check("rst_level", o_fifo_level, 3'd0);
    check("rst_rdy", o_wr_rdy, 1'b1);
    check("rst_on", o_lcd_on, 1'b0);
    check("rst_state", o_dbg_state, 3'd0);
    #2 i_reset = 1'b1;

    // table-driven single transfers
    for (int i = 0; i < 9; i++) begin
      send_single(vecs[i].rs, vecs[i].data, vecs[i].settle, vecs[i].name);
    end

    // burst of 6 offers, one per cycle, regardless of readiness
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      check("burst_rdy", o_wr_rdy, exp_rdy[k]);
      i_wr_vld  = 1'b1;
      i_wr_rs   = 1'b1;
      i_wr_data = 8'hA0 + 8'(k);
      if (exp_rdy[k]) exp_q.push_back({1'b1, 8'hA0 + 8'(k)});
      if (k == 5) check("burst_full_level", o_fifo_level, 3'd4);
      @(negedge clk);
    end
    i_wr_vld = 1'b0;
    check("burst_drop_level", o_fifo_level, 3'd4);
    drain("burst");

    // push+pop at level 1, then pointer wrap with 0x10..0x17
    @(negedge clk);
    i_wr_vld  = 1'b1;
    i_wr_rs   = 1'b1;
    i_wr_data = 8'h10;
    exp_q.push_back({1'b1, 8'h10});
    @(negedge clk);
    check("pp_level_pre", o_fifo_level, 3'd1);
    i_wr_data = 8'h11;
    exp_q.push_back({1'b1, 8'h11});
    @(negedge clk);
    check("pp_level_same", o_fifo_level, 3'd1);
    for (int k = 2; k < 8; k++) offer(1'b1, 8'h10 + 8'(k));
    i_wr_vld = 1'b0;
    drain("wrap");

    // reset in the middle of an EN pulse
    @(negedge clk);
    i_wr_vld = 1'b1;
    i_wr_rs  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_wr_data = 8'h5A + 8'(k);
      exp_q.push_back({1'b1, 8'h5A + 8'(k)});
      @(negedge clk);
    end
    i_wr_vld = 1'b0;
    t = 0;
    while (!o_lcd_en && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("mid_en_seen", o_lcd_en, 1'b1);
    check("mid_level_pre", o_fifo_level, 3'd2);
    #2 i_reset = 1'b0;
    #1;
    check("mid_en_async", o_lcd_en, 1'b0);
    check("mid_level_async", o_fifo_level, 3'd0);
    check("mid_rdy_async", o_wr_rdy, 1'b1);
    check("mid_busy_async", o_busy, 1'b0);
    check("mid_bus_async", {o_lcd_rs, o_lcd_data}, 9'h000);
    exp_q.delete();
    @(negedge clk);
    #2 i_reset = 1'b1;
    send_single(1'b1, 8'h55, THOLD + TCMD, "post_rst_55");

    // power pin follows with one flop of delay, no EN activity
    @(negedge clk);
    i_lcd_on = 1'b1;
    #1 check("on_hold0", o_lcd_on, 1'b0);
    @(negedge clk);
    check("on_rise", o_lcd_on, 1'b1);
    i_lcd_on = 1'b0;
    #1 check("on_hold1", o_lcd_on, 1'b1);
    @(negedge clk);
    check("on_fall", o_lcd_on, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("on_no_en", o_lcd_en, 1'b0);
      @(negedge clk);
    end

    check("final_sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
